sys_cmd_issuer: RTL and testbench

//  Host-side command initiator for the UART command protocol served by the system controller.

---
 rtl/sys_cmd_issuer_if.sv | 36 +++
 rtl/sys_cmd_issuer.sv | 139 +++++++++++++
 tb/tb_sys_cmd_issuer.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/sys_cmd_issuer_if.sv
// Request, UART byte-stream and response signals of the command issuer.
// The master modport is the issuer's view; slave is the host/UART side.
interface sys_cmd_issuer_if #(
    parameter int data_width   = 8,
    parameter int addr_width   = 4,
    parameter int alu_fn_width = 4
);
    logic                      req_valid;
    logic                      req_ready;
    logic [1:0]                req_type;
    logic [addr_width-1:0]     req_addr;
    logic [data_width-1:0]     req_data;
    logic [data_width-1:0]     req_op_a;
    logic [data_width-1:0]     req_op_b;
    logic [alu_fn_width-1:0]   req_fun;
    logic [data_width-1:0]     tx_data;
    logic                      tx_valid;
    logic                      tx_ready;
    logic [data_width-1:0]     rx_data;
    logic                      rx_valid;
    logic                      done;
    logic [2*data_width-1:0]   rsp_data;
    logic                      rsp_err;

    modport master (
        input  req_valid, req_type, req_addr, req_data, req_op_a, req_op_b, req_fun,
        input  tx_ready, rx_data, rx_valid,
        output req_ready, tx_data, tx_valid, done, rsp_data, rsp_err
    );

    modport slave (
        output req_valid, req_type, req_addr, req_data, req_op_a, req_op_b, req_fun,
        output tx_ready, rx_data, rx_valid,
        input  req_ready, tx_data, tx_valid, done, rsp_data, rsp_err
    );
endinterface

// File: rtl/sys_cmd_issuer.sv
// Host-side UART command initiator: serializes one request into an AA/BB/CC/DD frame,
// then gathers the reply bytes into a response word with timeout status.
module sys_cmd_issuer #(
    parameter int data_width   = 8,
    parameter int addr_width   = 4,
    parameter int alu_fn_width = 4,
    parameter int TIMEOUT_CYC  = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    sys_cmd_issuer_if.master  bus
);
    localparam int TW = $clog2(TIMEOUT_CYC);

    typedef enum logic [1:0] {IDLE, SEND, WAIT_RSP, DONE} state_t;

    state_t                  state, state_nxt;
    logic [data_width-1:0]   frame [4];
    logic [2:0]              frame_len;
    logic [1:0]              rsp_len;
    logic [1:0]              idx;
    logic [1:0]              cnt;
    logic [TW-1:0]           tmo;
    logic [data_width-1:0]   rx_buf0, rx_buf1;
    logic [data_width-1:0]   byte0_nxt, byte1_nxt;
    logic                    accept, tx_fire, last_tx, last_rx, expire;

    assign accept  = (state == IDLE) && bus.req_valid;
    assign tx_fire = (state == SEND) && bus.tx_ready;
    assign last_tx = (3'(idx) == frame_len - 3'd1);
    assign last_rx = (state == WAIT_RSP) && bus.rx_valid && (cnt == rsp_len - 2'd1);
    // A byte arriving on the expiry cycle takes precedence over the timeout.
    assign expire  = (state == WAIT_RSP) && !bus.rx_valid && (tmo == TW'(TIMEOUT_CYC - 1));

    assign byte0_nxt = (bus.rx_valid && cnt == 2'd0) ? bus.rx_data : rx_buf0;
    assign byte1_nxt = (bus.rx_valid && cnt == 2'd1) ? bus.rx_data : rx_buf1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        bus.req_ready = 1'b0;
        bus.tx_valid  = 1'b0;
        bus.tx_data   = '0;
        bus.done      = 1'b0;
        case (state)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) state_nxt = SEND;
            end
            SEND: begin
                bus.tx_valid = 1'b1;
                bus.tx_data  = frame[idx];
                if (tx_fire && last_tx) state_nxt = (rsp_len == 2'd0) ? DONE : WAIT_RSP;
            end
            WAIT_RSP: begin
                if (last_rx || expire) state_nxt = DONE;
            end
            DONE: begin
                bus.done  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) frame[i] <= '0;
            frame_len    <= '0;
            rsp_len      <= '0;
            idx          <= '0;
            cnt          <= '0;
            tmo          <= '0;
            rx_buf0      <= '0;
            rx_buf1      <= '0;
            bus.rsp_data <= '0;
            bus.rsp_err  <= 1'b0;
        end else begin
            if (accept) begin
                for (int i = 0; i < 4; i++) frame[i] <= '0;
                case (bus.req_type)
                    2'd0: begin
                        frame[0]  <= data_width'(8'hAA);
                        frame[1]  <= data_width'(bus.req_addr);
                        frame[2]  <= bus.req_data;
                        frame_len <= 3'd3;
                        rsp_len   <= 2'd0;
                    end
                    2'd1: begin
                        frame[0]  <= data_width'(8'hBB);
                        frame[1]  <= data_width'(bus.req_addr);
                        frame_len <= 3'd2;
                        rsp_len   <= 2'd1;
                    end
                    2'd2: begin
                        frame[0]  <= data_width'(8'hCC);
                        frame[1]  <= bus.req_op_a;
                        frame[2]  <= bus.req_op_b;
                        frame[3]  <= data_width'(bus.req_fun);
                        frame_len <= 3'd4;
                        rsp_len   <= 2'd2;
                    end
                    default: begin
                        frame[0]  <= data_width'(8'hDD);
                        frame[1]  <= data_width'(bus.req_fun);
                        frame_len <= 3'd2;
                        rsp_len   <= 2'd2;
                    end
                endcase
                idx          <= '0;
                cnt          <= '0;
                tmo          <= '0;
                rx_buf0      <= '0;
                rx_buf1      <= '0;
                bus.rsp_data <= '0;
                bus.rsp_err  <= 1'b0;
            end
            if (tx_fire) idx <= idx + 2'd1;
            if (state == WAIT_RSP) begin
                if (bus.rx_valid) begin
                    cnt     <= cnt + 2'd1;
                    tmo     <= '0;
                    rx_buf0 <= byte0_nxt;
                    rx_buf1 <= byte1_nxt;
                end else if (!expire) begin
                    tmo <= tmo + 1'b1;
                end
                if (last_rx || expire) begin
                    bus.rsp_data <= {byte1_nxt, byte0_nxt};
                    bus.rsp_err  <= expire;
                end
            end
        end
    end
endmodule

// File: tb/tb_sys_cmd_issuer.sv
// Directed bench for sys_cmd_issuer: expected frame bytes and responses are queued at
// stimulus time and checked by negedge monitors when the issuer emits them.
module tb_sys_cmd_issuer;
    localparam int T = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    logic [7:0]  tx_q  [$];
    logic [16:0] rsp_q [$];
    logic        held = 1'b0;
    logic [7:0]  held_byte = 8'h00;
    logic        prev_done = 1'b0;
    int          cyc;

    sys_cmd_issuer_if #(.data_width(8), .addr_width(4), .alu_fn_width(4)) bus ();

    sys_cmd_issuer #(.data_width(8), .addr_width(4), .alu_fn_width(4), .TIMEOUT_CYC(T)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Frame bytes, hold-while-stalled and response monitors.
    always @(negedge clk) begin
        if (rst_n) begin
            if (held && bus.tx_valid) chk("tx_stable", 32'(bus.tx_data), 32'(held_byte));
            held      = bus.tx_valid && !bus.tx_ready;
            held_byte = bus.tx_data;
            if (bus.tx_valid && bus.tx_ready) begin
                if (tx_q.size() == 0) chk("tx_unexpected", 32'(bus.tx_data), 32'hFFFF_FFFF);
                else                  chk("tx_byte", 32'(bus.tx_data), 32'(tx_q.pop_front()));
            end
            if (bus.done) begin
                chk("done_pulse", 32'(prev_done), 32'd0);
                if (rsp_q.size() == 0) chk("rsp_unexpected", 32'({bus.rsp_err, bus.rsp_data}), 32'hFFFF_FFFF);
                else                   chk("rsp", 32'({bus.rsp_err, bus.rsp_data}), 32'(rsp_q.pop_front()));
            end
            prev_done = bus.done;
        end else begin
            held      = 1'b0;
            prev_done = 1'b0;
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] t, input logic [3:0] a, input logic [7:0] d,
                         input logic [7:0] oa, input logic [7:0] ob, input logic [3:0] f);
        int n = 0;
        while (!bus.req_ready && n < 2000) begin cycle(); n++; end
        chk("ready_wait", 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1;
        bus.req_type  = t;
        bus.req_addr  = a;
        bus.req_data  = d;
        bus.req_op_a  = oa;
        bus.req_op_b  = ob;
        bus.req_fun   = f;
        case (t)
            2'd0: begin tx_q.push_back(8'hAA); tx_q.push_back({4'h0, a}); tx_q.push_back(d); end
            2'd1: begin tx_q.push_back(8'hBB); tx_q.push_back({4'h0, a}); end
            2'd2: begin tx_q.push_back(8'hCC); tx_q.push_back(oa); tx_q.push_back(ob);
                        tx_q.push_back({4'h0, f}); end
            default: begin tx_q.push_back(8'hDD); tx_q.push_back({4'h0, f}); end
        endcase
        cycle();
        bus.req_valid = 1'b0;
        bus.req_type  = 2'($urandom);
        bus.req_addr  = 4'($urandom);
        bus.req_data  = 8'($urandom);
        bus.req_op_a  = 8'($urandom);
        bus.req_op_b  = 8'($urandom);
        bus.req_fun   = 4'($urandom);
        chk("first_tx_valid", 32'(bus.tx_valid), 32'd1);
    endtask

    task automatic rx_byte(input logic [7:0] b);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        cycle();
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
    endtask

    task automatic wait_tx_drained();
        int n = 0;
        while (tx_q.size() != 0 && n < 100) begin cycle(); n++; end
        chk("tx_drain", 32'(tx_q.size()), 32'd0);
    endtask

    task automatic wait_done(output int c);
        c = 0;
        while (!bus.done && c < 4 * T) begin cycle(); c++; end
    endtask

    initial begin
        bus.req_valid = 1'b0; bus.req_type = 2'd0; bus.req_addr = 4'h0; bus.req_data = 8'h00;
        bus.req_op_a  = 8'h00; bus.req_op_b = 8'h00; bus.req_fun = 4'h0;
        bus.tx_ready  = 1'b1;  bus.rx_data  = 8'h00; bus.rx_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_tx_valid",  32'(bus.tx_valid),  32'd0);
        chk("rst_tx_data",   32'(bus.tx_data),   32'd0);
        chk("rst_done",      32'(bus.done),      32'd0);
        chk("rst_rsp",       32'({bus.rsp_err, bus.rsp_data}), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        cycle();

        // RF write: back-to-back bytes, done three edges after accept
        rsp_q.push_back(17'h0_0000);
        issue(2'd0, 4'h3, 8'h5A, 8'h00, 8'h00, 4'h0);
        wait_done(cyc);
        chk("wr_latency", 32'(cyc), 32'd3);
        cycle();

        // RF read with request held off during the reply wait
        rsp_q.push_back(17'h0_007E);
        issue(2'd1, 4'h2, 8'h00, 8'h00, 8'h00, 4'h0);
        wait_tx_drained();
        bus.req_valid = 1'b1; bus.req_type = 2'd0; bus.req_addr = 4'hF; bus.req_data = 8'h99;
        repeat (5) cycle();
        chk("busy_req_ready", 32'(bus.req_ready), 32'd0);
        repeat (5) cycle();
        bus.req_valid = 1'b0;
        rx_byte(8'h7E);
        chk("rd_done", 32'(bus.done), 32'd1);
        repeat (3) cycle();
        chk("rsp_held", 32'({bus.rsp_err, bus.rsp_data}), 32'h0_007E);

        // ALU with operands, tx_ready toggling and a stale rx byte during SEND
        rsp_q.push_back(17'h0_000D);
        bus.tx_ready = 1'b0;
        issue(2'd2, 4'h0, 8'h00, 8'h10, 8'h03, 4'h1);
        for (int i = 0; i < 40 && tx_q.size() != 0; i++) begin
            bus.tx_ready = ~bus.tx_ready;
            bus.rx_valid = (i == 2);
            bus.rx_data  = 8'hFF;
            cycle();
        end
        bus.rx_valid = 1'b0;
        chk("alu_tx_drain", 32'(tx_q.size()), 32'd0);
        bus.tx_ready = 1'b1;
        cycle();
        rx_byte(8'h0D);
        repeat (2) cycle();
        rx_byte(8'h00);
        chk("alu_done", 32'(bus.done), 32'd1);
        cycle();

        // ALU no-operand: one reply byte then silence until timeout
        rsp_q.push_back(17'h1_0044);
        issue(2'd3, 4'h0, 8'h00, 8'h00, 8'h00, 4'h2);
        wait_tx_drained();
        rx_byte(8'h44);
        wait_done(cyc);
        chk("timeout_cycles", 32'(cyc), 32'(T));
        cycle();

        // ALU no-operand: reply byte order, LSB first
        rsp_q.push_back(17'h0_1234);
        issue(2'd3, 4'h0, 8'h00, 8'h00, 8'h00, 4'h7);
        wait_tx_drained();
        rx_byte(8'h34);
        rx_byte(8'h12);
        chk("order_done", 32'(bus.done), 32'd1);
        cycle();

        // Reset after the second byte of an ALU frame
        issue(2'd2, 4'h0, 8'h00, 8'h21, 8'h43, 4'h5);
        cycle();
        cycle();
        chk("mid_bytes_left", 32'(tx_q.size()), 32'd2);
        rst_n = 1'b0;
        #1;
        chk("mid_tx_valid",  32'(bus.tx_valid),  32'd0);
        chk("mid_req_ready", 32'(bus.req_ready), 32'd1);
        chk("mid_rsp",       32'({bus.rsp_err, bus.rsp_data}), 32'd0);
        tx_q.delete();
        @(posedge clk); #1 rst_n = 1'b1;
        cycle();

        rsp_q.push_back(17'h0_005C);
        issue(2'd1, 4'h9, 8'h00, 8'h00, 8'h00, 4'h0);
        wait_tx_drained();
        rx_byte(8'h5C);
        chk("post_rst_done", 32'(bus.done), 32'd1);
        repeat (3) cycle();

        chk("tx_q_empty",  32'(tx_q.size()),  32'd0);
        chk("rsp_q_empty", 32'(rsp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
